// File: rtl/fp_unit_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and one shared floating-point unit.
// Latency: none; this file only carries wires.
// Backpressure: req_valid is held until req_ready; the unit side has no backpressure (go/finish pulses).
//
// Ports / signals:
//   req_valid/req_ready/req_a/req_b   requester side, operands packed requester i at [i*DBL_WIDTH +: DBL_WIDTH]
//   resp_valid/resp_data/resp_err     per-requester response pulse, shared data bus
//   unit_go/unit_a/unit_b             start pulse and registered operands toward the FP unit
//   unit_finish/unit_result           completion pulse and result from the FP unit
//   busy/err_timeout                  status
// The master modport is the arbiter; the slave modport is everything around it.
interface fp_unit_arbiter_if #(
    parameter int DBL_WIDTH = 64,
    parameter int NUM_REQ   = 4
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*DBL_WIDTH-1:0] req_a;
    logic [NUM_REQ*DBL_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]           resp_valid;
    logic [DBL_WIDTH-1:0]         resp_data;
    logic                         resp_err;
    logic                         unit_go;
    logic [DBL_WIDTH-1:0]         unit_a;
    logic [DBL_WIDTH-1:0]         unit_b;
    logic                         unit_finish;
    logic [DBL_WIDTH-1:0]         unit_result;
    logic                         busy;
    logic                         err_timeout;

    modport master (
        input  req_valid, req_a, req_b, unit_finish, unit_result,
        output req_ready, resp_valid, resp_data, resp_err,
               unit_go, unit_a, unit_b, busy, err_timeout
    );

    modport slave (
        output req_valid, req_a, req_b, unit_finish, unit_result,
        input  req_ready, resp_valid, resp_data, resp_err,
               unit_go, unit_a, unit_b, busy, err_timeout
    );
endinterface

// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter sharing one FP unit (valid/finish handshake) between NUM_REQ requesters, with a watchdog.
// Latency: grant edge -> unit_go next cycle; unit_finish in cycle k -> tagged resp_valid in cycle k+1.
// Backpressure: req_ready is a combinational one-hot grant, only while idle; one operation outstanding at a time.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   bus          fp_unit_arbiter_if.master (requests, tagged responses, unit go/finish, busy, err_timeout)
module fp_unit_arbiter #(
    parameter int DBL_WIDTH   = 64,
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    fp_unit_arbiter_if.master  bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    // Quiet NaN returned on a watchdog abort (0x7FF8_0000_0000_0000 for doubles).
    localparam logic [DBL_WIDTH-1:0] QNAN = {1'b0, {11{1'b1}}, 1'b1, {(DBL_WIDTH-13){1'b0}}};

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [PTR_W-1:0]     tag_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [DBL_WIDTH-1:0] unit_a_q, unit_b_q, resp_data_q;
    logic                 unit_go_q, resp_err_q, err_timeout_q;
    logic [NUM_REQ-1:0]   resp_valid_q;

    logic                 grant_found;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     cand;
    logic                 timeout_hit;
    logic [NUM_REQ-1:0]   req_ready_c;
    logic                 busy_c;

    logic [DBL_WIDTH-1:0] a_arr [NUM_REQ];
    logic [DBL_WIDTH-1:0] b_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr[gi] = bus.req_a[gi*DBL_WIDTH +: DBL_WIDTH];
        assign b_arr[gi] = bus.req_b[gi*DBL_WIDTH +: DBL_WIDTH];
    end

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search: first set req_valid bit at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // The counter starts at 0 in the unit_go cycle, so the abort lands TIMEOUT_CYC cycles after unit_go.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (grant_found) state_d = S_WAIT;
            S_WAIT: if (bus.unit_finish || timeout_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready_c = '0;
        busy_c      = 1'b0;
        if (state_q == S_IDLE) begin
            if (grant_found) req_ready_c = onehot(grant_idx);
        end else begin
            busy_c = 1'b1;
        end
    end

    // Datapath registers. unit_go, resp_valid and resp_err are single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q      <= '0;
            tag_q         <= '0;
            cnt_q         <= '0;
            unit_a_q      <= '0;
            unit_b_q      <= '0;
            unit_go_q     <= 1'b0;
            resp_valid_q  <= '0;
            resp_data_q   <= '0;
            resp_err_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            unit_go_q    <= 1'b0;
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            if (state_q == S_IDLE) begin
                // A unit_finish seen here is stale and deliberately ignored.
                if (grant_found) begin
                    unit_a_q  <= a_arr[grant_idx];
                    unit_b_q  <= b_arr[grant_idx];
                    tag_q     <= grant_idx;
                    rr_ptr_q  <= PTR_W'((int'(grant_idx) + 1) % NUM_REQ);
                    unit_go_q <= 1'b1;
                    cnt_q     <= '0;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
                // Finish takes priority over a coincident timeout.
                if (bus.unit_finish) begin
                    resp_data_q  <= bus.unit_result;
                    resp_valid_q <= onehot(tag_q);
                end else if (timeout_hit) begin
                    resp_data_q   <= QNAN;
                    resp_valid_q  <= onehot(tag_q);
                    resp_err_q    <= 1'b1;
                    err_timeout_q <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready   = req_ready_c;
    assign bus.busy        = busy_c;
    assign bus.unit_go     = unit_go_q;
    assign bus.unit_a      = unit_a_q;
    assign bus.unit_b      = unit_b_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_data   = resp_data_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Testbench for fp_unit_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Latency: model expects unit_go one cycle after grant and resp_valid one cycle after finish/abort.
// Backpressure: requesters hold req_valid until granted; a behavioural multiplier answers unit_go.
module tb_fp_unit_arbiter;
    localparam int NR = 4;
    localparam int DW = 64;
    localparam int TO = 8;
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_unit_arbiter_if #(.DBL_WIDTH(DW), .NUM_REQ(NR)) bus();

    fp_unit_arbiter #(.DBL_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: pending requests, their operands, the next-in-line pointer and sticky error.
    bit [NR-1:0] pend;
    logic [63:0] opa [NR];
    logic [63:0] opb [NR];
    int          rr;
    bit          sticky;
    logic [63:0] last_resp;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int pick();
        for (int i = 0; i < NR; i++)
            if (pend[(rr + i) % NR]) return (rr + i) % NR;
        return -1;
    endfunction

    function automatic logic [63:0] mul(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) * $bitstoreal(b));
    endfunction

    task automatic add_req(input int i, input real a, input real b);
        pend[i] = 1'b1;
        opa[i]  = $realtobits(a);
        opb[i]  = $realtobits(b);
    endtask

    task automatic add_rand(input int i);
        add_req(i, $itor($urandom_range(0, 64)) / 8.0, $itor($urandom_range(0, 64)) / 8.0);
    endtask

    task automatic drive_req();
        bus.req_valid = pend;
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i*DW +: DW] = opa[i];
            bus.req_b[i*DW +: DW] = opb[i];
        end
    endtask

    // One transaction from a negedge with pending requests: grant, wait, finish at offset fd
    // after unit_go (or abort), response; optionally a late stale finish afterwards.
    task automatic run_txn(input int fd, input bit late, input bit reassert);
        int          g;
        logic [63:0] exp;
        bit          finished;
        g = pick();
        if (g < 0) return;
        drive_req();
        #1;
        chk("grant", bus.req_ready, oh(g));
        exp      = mul(opa[g], opb[g]);
        pend[g]  = 1'b0;
        rr       = (g + 1) % NR;
        finished = 1'b0;
        for (int j = 0; j < TO; j++) begin
            @(negedge clk);
            chk("unit_go", bus.unit_go, (j == 0));
            if (j == 0) begin
                chk("unit_a", bus.unit_a, opa[g]);
                chk("unit_b", bus.unit_b, opb[g]);
            end
            chk("busy_wait", bus.busy, 1);
            chk("resp_quiet", bus.resp_valid, 0);
            drive_req();
            #1;
            chk("ready_in_wait", bus.req_ready, 0);
            if (j == fd) begin
                bus.unit_finish = 1'b1;
                bus.unit_result = exp;
                finished = 1'b1;
                break;
            end
            bus.unit_result = {$urandom, $urandom};
        end
        @(negedge clk);
        bus.unit_finish = 1'b0;
        if (!finished) sticky = 1'b1;
        chk("resp_valid", bus.resp_valid, oh(g));
        chk("resp_data", bus.resp_data, finished ? exp : QNAN);
        chk("resp_err", bus.resp_err, !finished);
        chk("err_timeout", bus.err_timeout, sticky);
        chk("busy_done", bus.busy, 0);
        last_resp = bus.resp_data;
        if (reassert) add_rand(g);
        if (late && !finished && pend == 0) begin
            repeat (2) begin
                drive_req();
                @(negedge clk);
                chk("late_pre", bus.resp_valid, 0);
            end
            bus.unit_finish = 1'b1;
            bus.unit_result = {$urandom, $urandom};
            @(negedge clk);
            bus.unit_finish = 1'b0;
            chk("late_ignored", bus.resp_valid, 0);
            chk("late_busy", bus.busy, 0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, bus.req_ready, 0);
        chk({tag, "_rvalid"}, bus.resp_valid, 0);
        chk({tag, "_rdata"}, bus.resp_data, 0);
        chk({tag, "_rerr"}, bus.resp_err, 0);
        chk({tag, "_go"}, bus.unit_go, 0);
        chk({tag, "_ua"}, bus.unit_a, 0);
        chk({tag, "_ub"}, bus.unit_b, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_errto"}, bus.err_timeout, 0);
    endtask

    initial begin
        int g;
        pend            = '0;
        rr              = 0;
        sticky          = 1'b0;
        last_resp       = '0;
        for (int i = 0; i < NR; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        bus.req_valid   = '0;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.unit_finish = 1'b0;
        bus.unit_result = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Fairness: all four held and re-asserted after each response.
        for (int i = 0; i < NR; i++) add_rand(i);
        for (int i = 0; i < 8; i++) begin
            drive_req();
            #1;
            chk("fair_order", bus.req_ready, oh(i % NR));
            run_txn($urandom_range(1, 5), 1'b0, 1'b1);
        end
        pend = '0;

        // Single request 2.0 * 3.0, finish 5 cycles after unit_go.
        add_req(0, 2.0, 3.0);
        run_txn(5, 1'b0, 1'b0);
        chk("single_data", last_resp, 64'h4018_0000_0000_0000);

        // Wrap-around: grant 2, then 0 and 3 pending -> 3 first, then 0.
        add_rand(2);
        run_txn(2, 1'b0, 1'b0);
        add_rand(0);
        add_rand(3);
        drive_req();
        #1;
        chk("wrap_first", bus.req_ready, 4'b1000);
        run_txn(1, 1'b0, 1'b0);
        run_txn(3, 1'b0, 1'b0);

        // Timeout with a late finish, then finish coinciding with the timeout cycle.
        add_rand(1);
        run_txn(100, 1'b1, 1'b0);
        chk("timeout_data", last_resp, QNAN);
        add_rand(2);
        run_txn(TO - 1, 1'b0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 120; n++) begin
            for (int i = 0; i < NR; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0) add_rand(i);
            if ($urandom_range(0, 9) == 0) pend[$urandom_range(0, NR - 1)] = 1'b0;
            if (pend == 0) begin
                drive_req();
                #1;
                chk("idle_ready", bus.req_ready, 0);
                @(negedge clk);
            end else begin
                run_txn($urandom_range(1, TO + 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        // Reset two cycles after unit_go, then a stale finish.
        pend = '0;
        add_rand(1);
        add_rand(2);
        g = pick();
        drive_req();
        #1;
        chk("pre_reset_grant", bus.req_ready, oh(g));
        pend[g] = 1'b0;
        @(negedge clk);
        chk("pre_reset_go", bus.unit_go, 1);
        repeat (2) @(negedge clk);
        pend = '0;
        drive_req();
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        rr     = 0;
        sticky = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.unit_finish = 1'b1;
        @(negedge clk);
        bus.unit_finish = 1'b0;
        chk("stale_rvalid", bus.resp_valid, 0);
        chk("stale_busy", bus.busy, 0);
        chk("stale_errto", bus.err_timeout, 0);
        add_rand(0);
        add_rand(3);
        drive_req();
        #1;
        chk("post_reset_grant", bus.req_ready, 4'b0001);
        run_txn(2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fp_unit_arbiter.md
Name: fp_unit_arbiter

Overview:
- Round-robin arbiter that shares one floating-point unit (fp_multiplier or fp_adder, valid/finish handshake) between NUM_REQ covariance-update requesters.
- Each requester presents an operand pair. The arbiter grants one, drives the unit, and returns the result tagged to that requester.
- A watchdog guards against a missing finish.
- Instantiated once per shared unit, so two instances share one multiplier and one adder.

Parameters:
- DBL_WIDTH, 64, operand/result width (IEEE-754 double).
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 64, max cycles from unit_go to unit_finish before abort.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester request; held until accepted.
- req_ready  output  NUM_REQ  one-hot grant; combinational, only in S_IDLE.
- req_a  input  NUM_REQ*DBL_WIDTH  operand a; requester i at slice [i*DBL_WIDTH +: DBL_WIDTH].
- req_b  input  NUM_REQ*DBL_WIDTH  operand b, same packing.
- resp_valid  output  NUM_REQ  one-cycle pulse to the owning requester.
- resp_data  output  DBL_WIDTH  result; valid only while some resp_valid bit is high.
- resp_err  output  1  high with resp_valid when the response is a timeout abort.
- unit_go  output  1  one-cycle start pulse to the shared unit.
- unit_a  output  DBL_WIDTH  unit operand a (registered).
- unit_b  output  DBL_WIDTH  unit operand b (registered).
- unit_finish  input  1  unit completion pulse.
- unit_result  input  DBL_WIDTH  unit result, valid with unit_finish.
- busy  output  1  high in S_WAIT.
- err_timeout  output  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Reset values: state S_IDLE, rr_ptr 0, tag 0, wait counter 0. All outputs 0: req_ready, resp_valid, resp_data, resp_err, unit_go, unit_a, unit_b, busy, err_timeout.
- S_IDLE, arbitration:
  - Search req_valid starting at rr_ptr, ascending with wrap; the first set bit g wins.
  - req_ready = onehot(g) that cycle, so acceptance is req_valid[g] & req_ready[g] at the edge.
  - On that edge: unit_a <= req_a[g], unit_b <= req_b[g], tag <= g, rr_ptr <= (g+1) mod NUM_REQ, unit_go <= 1, counter <= 0, go to S_WAIT.
  - No request: stay in S_IDLE, rr_ptr unchanged.
- S_WAIT:
  - unit_go is 0 after its single-cycle pulse; req_ready is all 0.
  - The counter increments each cycle.
  - unit_finish = 1: resp_data <= unit_result, resp_valid[tag] <= 1 (pulse next cycle), resp_err <= 0, go to S_IDLE.
  - Counter reaches TIMEOUT_CYC-1 without finish:
    - resp_data <= 64'h7FF8_0000_0000_0000 (quiet NaN), resp_valid[tag] <= 1, resp_err <= 1, err_timeout <= 1, go to S_IDLE.
    - If unit_finish arrives in that same cycle, finish wins: normal response, no error.
- Latency:
  - Accept edge t → unit_go high in cycle t+1.
  - Finish in cycle k → resp_valid in cycle k+1.
  - The arbiter is back in S_IDLE in cycle k+1 and may grant in that same cycle (back-to-back, no bubble beyond the unit's own latency).
  - The unit may assert finish in the cycle immediately after unit_go.
- unit_finish seen in S_IDLE (stale, or late after timeout) is ignored; no response is produced.
- Requesters may drop req_valid before grant; it is not a protocol error. Operands are sampled only on the accept edge.
- resp_valid and unit_go are default-0 every cycle and set only as above. At most one resp_valid bit is ever high.
- Reset mid-S_WAIT: the in-flight operation is dropped, no response is issued, and a later unit_finish is ignored as stale.
- Only one operation is outstanding at a time; the unit is never given a second unit_go before finish or timeout.

Test Plan:
- Single request: req_valid=4'b0001, a=2.0, b=3.0 → unit_go one cycle later with unit_a=2.0, unit_b=3.0. Model finish after 5 cycles with 6.0 → resp_valid=4'b0001 and resp_data=0x4018000000000000 one cycle after finish; resp_err=0.
- Contention/fairness: req_valid=4'b1111 held, each requester re-asserting after its response. Over 8 grants the order is 0,1,2,3,0,1,2,3, with no grant during S_WAIT.
- Wrap-around: rr_ptr=3 (after grant to 2), requests on 0 and 3 → 3 granted first, then 0.
- Timeout: TIMEOUT_CYC=8, unit never finishes → 8 cycles after unit_go, resp_valid to the owner with resp_data=0x7FF8000000000000 and resp_err=1; err_timeout stays 1. A late unit_finish 3 cycles later produces no response.
- Finish and timeout in the same cycle: finish wins, resp_err=0, err_timeout unchanged.
- Reset mid-wait: assert rst_n=0 two cycles after unit_go, release, then pulse unit_finish → all outputs 0, no resp_valid, next request granted normally starting from requester 0.
